// File: rtl/ru_pkg.sv
// Shared constants and entry layout for the update write-back path.
package ru_pkg;

  localparam int ADDRW_DEF = 16;
  localparam int WL_DEF    = 32;

  typedef struct packed {
    logic [ADDRW_DEF-1:0] dst;
    logic [WL_DEF-1:0]    value;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write buffer: storage, wrapping pointers, occupancy count, full/empty.
// Exposes per-slot contents and occupancy so the owner can search pending entries.
module wb_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [W-1:0]     mem [DEPTH],
  output logic [DEPTH-1:0] occupied
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale slots are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      occupied[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/update_writeback.sv
// Buffers update-pipeline results and writes them to feature memory in order.
// Optional macro HAZARD_CHECK_EN stalls source reads that hit a pending write.
module update_writeback
  import ru_pkg::*;
#(
  parameter int ADDRW     = ADDRW_DEF,
  parameter int WL        = WL_DEF,
  parameter int FIFODEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall,
  input  logic             invalid,
  input  logic [ADDRW-1:0] indst,
  input  logic [WL-1:0]    invalue,
  input  logic             chkvalid,
  input  logic [ADDRW-1:0] chksrc,
  output logic             stallwrite,
  output logic             wrreq,
  output logic [ADDRW-1:0] wraddr,
  output logic [WL-1:0]    wrdata,
  input  logic             wrgrant,
  output logic [31:0]      wrcount
);

  localparam int EW = ADDRW + WL;

  typedef struct packed {
    logic [ADDRW-1:0] dst;
    logic [WL-1:0]    value;
  } entry_t;

  entry_t               push_entry;
  entry_t               head_entry;
  logic [EW-1:0]        head_bits;
  logic [EW-1:0]        entry_mem [FIFODEPTH];
  logic [FIFODEPTH-1:0] occupied;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 hazard;

  assign push_entry = '{dst: indst, value: invalue};
  assign push       = invalid && ena && !stall && !stallwrite;
  assign pop        = wrreq && wrgrant;
  assign stallwrite = full || hazard;
  assign wrreq      = !empty;
  assign head_entry = entry_t'(head_bits);
  // Outputs read zero whenever nothing is pending, including throughout reset.
  assign wraddr     = wrreq ? head_entry.dst   : '0;
  assign wrdata     = wrreq ? head_entry.value : '0;

  wb_fifo #(
    .W     (EW),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (push_entry),
    .head     (head_bits),
    .full     (full),
    .empty    (empty),
    .mem      (entry_mem),
    .occupied (occupied)
  );

`ifdef HAZARD_CHECK_EN
  always_comb begin
    entry_t e;
    logic   hit;
    hit = invalid && (chksrc == indst);
    for (int i = 0; i < FIFODEPTH; i++) begin
      e = entry_t'(entry_mem[i]);
      if (occupied[i] && (e.dst == chksrc)) hit = 1'b1;
    end
    hazard = chkvalid && hit;
  end
`else
  logic unused_fold;

  assign hazard = 1'b0;

  always_comb begin
    unused_fold = chkvalid ^ (^chksrc) ^ (^occupied);
    for (int i = 0; i < FIFODEPTH; i++) unused_fold = unused_fold ^ (^entry_mem[i]);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrcount <= '0;
    else if (pop) wrcount <= wrcount + 32'd1;
  end

endmodule

// File: tb/tb_update_writeback.sv
// Directed self-checking bench for update_writeback (default FIFODEPTH = 4).
module tb_update_writeback;
  import ru_pkg::*;

  logic        clk = 0;
  logic        rst;
  logic        ena, stall, invalid, chkvalid, wrgrant;
  logic [15:0] indst, chksrc, wraddr;
  logic [31:0] invalue, wrdata, wrcount;
  logic        stallwrite, wrreq;

  int checks = 0;
  int errors = 0;
  int exp_wrcount = 0;
  wb_entry_t log_q[$];

`ifdef HAZARD_CHECK_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  update_writeback dut (
    .clk(clk), .rst(rst), .ena(ena), .stall(stall), .invalid(invalid),
    .indst(indst), .invalue(invalue), .chkvalid(chkvalid), .chksrc(chksrc),
    .stallwrite(stallwrite), .wrreq(wrreq), .wraddr(wraddr), .wrdata(wrdata),
    .wrgrant(wrgrant), .wrcount(wrcount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrreq && wrgrant) log_q.push_back('{dst: wraddr, value: wrdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; ena = 1; stall = 0; invalid = 0; chkvalid = 0; wrgrant = 0;
    indst = 0; chksrc = 0; invalue = 0;
    tick(); tick();
    checks++;
    if (wrreq !== 1'b0 || stallwrite !== 1'b0 || wrcount !== 32'd0 ||
        wraddr !== 16'd0 || wrdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state wrreq=%b stallwrite=%b wrcount=%0d wraddr=%h wrdata=%h expected all zero",
               wrreq, stallwrite, wrcount, wraddr, wrdata);
    end
    rst = 0;
    tick();
    exp_wrcount = 0;
    log_q.delete();
  endtask

  task automatic test_single();
    wrgrant = 1; invalid = 1; indst = 16'h0005; invalue = 32'h3F80_0000;
    tick();
    invalid = 0;
    #1;
    checks++;
    if (wrreq !== 1'b1 || wraddr !== 16'h0005 || wrdata !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL single_head wrreq=%b wraddr=%h wrdata=%h expected 1 0005 3f800000", wrreq, wraddr, wrdata);
    end
    tick();
    exp_wrcount++;
    checks++;
    if (wrreq !== 1'b0 || wrcount !== 32'(exp_wrcount)) begin
      errors++;
      $display("FAIL single_retire wrreq=%b wrcount=%0d expected 0 %0d", wrreq, wrcount, exp_wrcount);
    end
    checks++;
    if (log_q.size() != 1) begin
      errors++;
      $display("FAIL single_count writes=%0d expected 1", log_q.size());
    end
    log_q.delete();
  endtask

  task automatic test_fill();
    wrgrant = 0;
    for (int i = 0; i < 4; i++) begin
      invalid = 1; indst = 16'h0020 + 16'(i); invalue = 32'h0100 + 32'(i);
      tick();
    end
    invalid = 1; indst = 16'h0024; invalue = 32'h0104;
    #1;
    checks++;
    if (stallwrite !== 1'b1 || wrreq !== 1'b1 || wraddr !== 16'h0020) begin
      errors++;
      $display("FAIL fill_full stallwrite=%b wrreq=%b wraddr=%h expected 1 1 0020", stallwrite, wrreq, wraddr);
    end
    tick(); tick();
    checks++;
    if (stallwrite !== 1'b1) begin
      errors++;
      $display("FAIL fill_hold stallwrite=%b expected 1", stallwrite);
    end
    wrgrant = 1;
    tick();
    exp_wrcount++;
    wrgrant = 0;
    #1;
    checks++;
    if (stallwrite !== 1'b0 || wraddr !== 16'h0021) begin
      errors++;
      $display("FAIL fill_release stallwrite=%b wraddr=%h expected 0 0021", stallwrite, wraddr);
    end
    tick();
    invalid = 0;
    #1;
    checks++;
    if (stallwrite !== 1'b1) begin
      errors++;
      $display("FAIL fill_refull stallwrite=%b expected 1", stallwrite);
    end
    wrgrant = 1;
    for (int i = 0; i < 6; i++) tick();
    exp_wrcount += 4;
    checks++;
    if (log_q.size() != 5) begin
      errors++;
      $display("FAIL fill_count writes=%0d expected 5", log_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_q[i].dst !== 16'h0020 + 16'(i) || log_q[i].value !== 32'h0100 + 32'(i)) begin
          errors++;
          $display("FAIL fill_order[%0d] got %h/%h expected %h/%h", i, log_q[i].dst, log_q[i].value,
                   16'h0020 + 16'(i), 32'h0100 + 32'(i));
        end
      end
    end
    checks++;
    if (wrreq !== 1'b0 || wrcount !== 32'(exp_wrcount)) begin
      errors++;
      $display("FAIL fill_drain wrreq=%b wrcount=%0d expected 0 %0d", wrreq, wrcount, exp_wrcount);
    end
    log_q.delete();
  endtask

  task automatic test_stall_hold();
    wrgrant = 1;
    invalid = 1; indst = 16'h0030; invalue = 32'hDEAD_0030;
    ena = 0;
    tick(); tick();
    ena = 1; stall = 1;
    tick(); tick(); tick();
    checks++;
    if (wrreq !== 1'b0 || log_q.size() != 0) begin
      errors++;
      $display("FAIL stall_nopush wrreq=%b writes=%0d expected 0 0", wrreq, log_q.size());
    end
    stall = 0;
    tick();
    invalid = 0;
    for (int i = 0; i < 3; i++) tick();
    exp_wrcount++;
    checks++;
    if (log_q.size() != 1 || log_q[0].dst !== 16'h0030 || wrcount !== 32'(exp_wrcount)) begin
      errors++;
      $display("FAIL stall_once writes=%0d wrcount=%0d expected 1 %0d", log_q.size(), wrcount, exp_wrcount);
    end
    log_q.delete();
  endtask

  task automatic test_hazard();
    wrgrant = 0;
    invalid = 1; indst = 16'h0010; invalue = 32'h0000_00AA;
    tick();
    invalid = 0; chkvalid = 1; chksrc = 16'h0010;
    #1;
    checks++;
    if (stallwrite !== HZ) begin
      errors++;
      $display("FAIL hazard_hit stallwrite=%b expected %b", stallwrite, HZ);
    end
    tick();
    checks++;
    if (stallwrite !== HZ || wrreq !== 1'b1) begin
      errors++;
      $display("FAIL hazard_persist stallwrite=%b wrreq=%b expected %b 1", stallwrite, wrreq, HZ);
    end
    chksrc = 16'h0011;
    #1;
    checks++;
    if (stallwrite !== 1'b0) begin
      errors++;
      $display("FAIL hazard_miss stallwrite=%b expected 0", stallwrite);
    end
    invalid = 1; indst = 16'h0011;
    #1;
    checks++;
    if (stallwrite !== HZ) begin
      errors++;
      $display("FAIL hazard_incoming stallwrite=%b expected %b", stallwrite, HZ);
    end
    invalid = 0; chksrc = 16'h0010; wrgrant = 1;
    tick();
    exp_wrcount++;
    checks++;
    if (stallwrite !== 1'b0 || wrreq !== 1'b0) begin
      errors++;
      $display("FAIL hazard_retired stallwrite=%b wrreq=%b expected 0 0", stallwrite, wrreq);
    end
    chkvalid = 0;
    tick();
    log_q.delete();
  endtask

  task automatic test_reset_mid();
    wrgrant = 0;
    for (int i = 0; i < 3; i++) begin
      invalid = 1; indst = 16'h0050 + 16'(i); invalue = 32'h0500 + 32'(i);
      tick();
    end
    invalid = 0;
    wrgrant = 1;
    rst = 1;
    #1;
    checks++;
    if (wrreq !== 1'b0 || wrcount !== 32'd0 || wraddr !== 16'd0 || stallwrite !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear wrreq=%b wrcount=%0d wraddr=%h stallwrite=%b expected 0 0 0000 0",
               wrreq, wrcount, wraddr, stallwrite);
    end
    tick();
    rst = 0;
    exp_wrcount = 0;
    log_q.delete();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (wrreq !== 1'b0 || log_q.size() != 0 || wrcount !== 32'd0) begin
      errors++;
      $display("FAIL midreset_stale wrreq=%b writes=%0d wrcount=%0d expected 0 0 0", wrreq, log_q.size(), wrcount);
    end
    log_q.delete();
  endtask

  task automatic test_wrap();
    int sw_seen = 0;
    wrgrant = 1;
    for (int i = 0; i < 10; i++) begin
      invalid = 1; indst = 16'h0060 + 16'(i); invalue = 32'h1000 + 32'(i);
      #1;
      if (stallwrite !== 1'b0) sw_seen++;
      tick();
    end
    invalid = 0;
    tick(); tick(); tick();
    exp_wrcount += 10;
    checks++;
    if (sw_seen != 0) begin
      errors++;
      $display("FAIL wrap_stall stallwrite high %0d cycles expected 0", sw_seen);
    end
    checks++;
    if (log_q.size() != 10) begin
      errors++;
      $display("FAIL wrap_count writes=%0d expected 10", log_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (log_q[i].dst !== 16'h0060 + 16'(i) || log_q[i].value !== 32'h1000 + 32'(i)) begin
          errors++;
          $display("FAIL wrap_order[%0d] got %h/%h expected %h/%h", i, log_q[i].dst, log_q[i].value,
                   16'h0060 + 16'(i), 32'h1000 + 32'(i));
        end
      end
    end
    checks++;
    if (wrcount !== 32'd10 || wrcount !== 32'(exp_wrcount)) begin
      errors++;
      $display("FAIL wrap_wrcount got %0d expected 10", wrcount);
    end
    log_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stall_hold();
    test_hazard();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
